// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-macro signals of the shared RAM port
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  m_en;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0] m_rdata;
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_we, m_addr, m_wdata
  );
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: data-first single-port RAM arbiter with fetch anti-starvation and response routing
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic [CNT_WIDTH-1:0] conflict_count
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {NONE, IFETCH, DREAD} owner_t;
  owner_t owner;
  logic [SW-1:0] starve_cnt;
  logic starved;
  assign starved = starve_cnt == SW'(STARVE_LIMIT);
  // grants are purely combinational on requests and registered state; reset blocks them outright
  always_comb begin
    bus.d_gnt    = !reset && bus.d_req && !(bus.i_req && starved);
    bus.i_gnt    = !reset && bus.i_req && !bus.d_gnt;
    bus.m_en     = bus.i_gnt || bus.d_gnt;
    bus.m_we     = bus.d_gnt && bus.d_we;
    bus.m_addr   = bus.d_gnt ? bus.d_addr : bus.i_gnt ? bus.i_addr : '0;
    bus.m_wdata  = bus.d_gnt ? bus.d_wdata : '0;
    bus.i_rvalid = !reset && owner == IFETCH;
    bus.d_rvalid = !reset && owner == DREAD;
    bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : '0;
    bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;
  end
  // owner of next cycle's read data, fetch starvation tracking and saturating conflict counter
  always_ff @(posedge clock) begin
    if (reset) begin
      owner          <= NONE;
      starve_cnt     <= '0;
      conflict_count <= '0;
    end else begin
      owner          <= bus.i_gnt ? IFETCH : (bus.d_gnt && !bus.d_we) ? DREAD : NONE;
      starve_cnt     <= (!bus.i_req || bus.i_gnt) ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
      conflict_count <= (bus.i_req && bus.d_req && !(&conflict_count)) ? conflict_count + 1'b1 : conflict_count;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, corner sequences and random traffic against a behavioural model
module tb_mem_port_arbiter;
  localparam int STARVE = 4;
  localparam int CMAX = 15;
  logic clock, reset;
  logic [3:0] conflict_count;
  mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();
  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STARVE_LIMIT(STARVE), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .bus(bus), .conflict_count(conflict_count)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  logic [31:0] ram [0:255];
  always @(posedge clock)
    if (bus.m_en) begin
      if (bus.m_we) ram[bus.m_addr[7:0]] <= bus.m_wdata;
      else bus.m_rdata <= ram[bus.m_addr[7:0]];
    end
  int checks = 0, errors = 0;
  logic [31:0] mm [0:255];
  int m_starve, m_conf, pend;
  logic [31:0] pend_data;
  logic eg_i, eg_d, conf;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic sample();
    logic ev_i, ev_d;
    @(negedge clock);
    conf = bus.i_req && bus.d_req;
    eg_d = !reset && bus.d_req && !(bus.i_req && m_starve == STARVE);
    eg_i = !reset && bus.i_req && !eg_d;
    ev_i = !reset && pend == 1;
    ev_d = !reset && pend == 2;
    chk("i_gnt", bus.i_gnt, eg_i);
    chk("d_gnt", bus.d_gnt, eg_d);
    chk("m_en", bus.m_en, eg_i || eg_d);
    chk("m_we", bus.m_we, eg_d && bus.d_we);
    chk("m_addr", bus.m_addr, eg_d ? bus.d_addr : eg_i ? bus.i_addr : 16'h0);
    chk("m_wdata", bus.m_wdata, eg_d ? bus.d_wdata : 32'h0);
    chk("i_rvalid", bus.i_rvalid, ev_i);
    chk("i_rdata", bus.i_rdata, ev_i ? pend_data : 32'h0);
    chk("d_rvalid", bus.d_rvalid, ev_d);
    chk("d_rdata", bus.d_rdata, ev_d ? pend_data : 32'h0);
    chk("conflict_count", conflict_count, 64'(m_conf));
  endtask
  task automatic advance();
    @(posedge clock);
    if (reset) begin
      m_starve = 0;
      m_conf = 0;
      pend = 0;
    end else begin
      pend = eg_i ? 1 : (eg_d && !bus.d_we) ? 2 : 0;
      if (eg_i) pend_data = mm[bus.i_addr[7:0]];
      if (eg_d && !bus.d_we) pend_data = mm[bus.d_addr[7:0]];
      if (eg_d && bus.d_we) mm[bus.d_addr[7:0]] = bus.d_wdata;
      m_starve = (!bus.i_req || eg_i) ? 0 : (m_starve < STARVE ? m_starve + 1 : STARVE);
      if (conf && m_conf < CMAX) m_conf++;
    end
    #1;
  endtask
  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dwe,
                       input logic [15:0] da, input logic [31:0] dwd);
    bus.i_req = ir; bus.i_addr = ia; bus.d_req = dr; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
  endtask
  typedef struct {
    logic ir; logic [15:0] ia; logic dr; logic dwe; logic [15:0] da; logic [31:0] dwd;
    logic eig; logic edg; logic eiv; logic [31:0] eid; logic edv; logic [31:0] edd;
  } vec_t;
  vec_t tbl [8];
  initial begin
    for (int k = 0; k < 256; k++) begin
      ram[k] = 32'(k) * 32'h01010101 ^ 32'h5a5a0000;
      mm[k] = ram[k];
    end
    ram[16] = 32'hDEADBEEF;
    mm[16] = 32'hDEADBEEF;
    m_starve = 0; m_conf = 0; pend = 0; pend_data = 0;
    tbl[0] = '{1, 16'h10, 0, 0, 16'h0, 32'h0,    1, 0, 0, 32'h0,        0, 32'h0};
    tbl[1] = '{0, 16'h0, 1, 1, 16'h20, 32'h1234, 0, 1, 1, 32'hDEADBEEF, 0, 32'h0};
    tbl[2] = '{0, 16'h0, 1, 0, 16'h20, 32'h0,    0, 1, 0, 32'h0,        0, 32'h0};
    tbl[3] = '{0, 16'h0, 0, 0, 16'h0, 32'h0,     0, 0, 0, 32'h0,        1, 32'h1234};
    tbl[4] = '{1, 16'h20, 0, 0, 16'h0, 32'h0,    1, 0, 0, 32'h0,        0, 32'h0};
    tbl[5] = '{0, 16'h0, 1, 0, 16'h10, 32'h0,    0, 1, 1, 32'h1234,     0, 32'h0};
    tbl[6] = '{1, 16'h10, 0, 0, 16'h0, 32'h0,    1, 0, 0, 32'h0,        1, 32'hDEADBEEF};
    tbl[7] = '{0, 16'h0, 0, 0, 16'h0, 32'h0,     0, 0, 1, 32'hDEADBEEF, 0, 32'h0};
    reset = 1;
    drive(1, 16'h10, 1, 0, 16'h20, 32'h0);
    repeat (2) begin
      sample();
      chk("reset_no_gnt", {bus.i_gnt, bus.d_gnt, bus.m_en}, 3'b000);
      advance();
    end
    reset = 0;
    drive(0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 8; r++) begin
      drive(tbl[r].ir, tbl[r].ia, tbl[r].dr, tbl[r].dwe, tbl[r].da, tbl[r].dwd);
      sample();
      chk($sformatf("row%0d_i_gnt", r), bus.i_gnt, tbl[r].eig);
      chk($sformatf("row%0d_d_gnt", r), bus.d_gnt, tbl[r].edg);
      chk($sformatf("row%0d_i_rvalid", r), bus.i_rvalid, tbl[r].eiv);
      chk($sformatf("row%0d_i_rdata", r), bus.i_rdata, tbl[r].eid);
      chk($sformatf("row%0d_d_rvalid", r), bus.d_rvalid, tbl[r].edv);
      chk($sformatf("row%0d_d_rdata", r), bus.d_rdata, tbl[r].edd);
      advance();
    end
    drive(0, 0, 1, 0, 16'h10, 0);
    sample();
    chk("rst_mid_d_gnt", bus.d_gnt, 1'b1);
    advance();
    reset = 1;
    sample();
    chk("rst_mid_d_rvalid", bus.d_rvalid, 1'b0);
    chk("rst_mid_outputs", {bus.i_gnt, bus.d_gnt, bus.m_en, bus.m_we, bus.i_rvalid, bus.d_rdata}, 36'h0);
    advance();
    reset = 0;
    drive(0, 0, 0, 0, 0, 0);
    sample();
    chk("post_rst_d_rvalid", bus.d_rvalid, 1'b0);
    advance();
    drive(1, 16'h3, 1, 0, 16'h7, 0);
    for (int k = 0; k < 20; k++) begin
      sample();
      chk("starve_i_gnt", bus.i_gnt, k % 5 == 4);
      chk("starve_d_gnt", bus.d_gnt, k % 5 != 4);
      chk("starve_conflict", conflict_count, 64'(k < CMAX ? k : CMAX));
      advance();
    end
    reset = 1;
    drive(0, 0, 0, 0, 0, 0);
    sample();
    advance();
    reset = 0;
    for (int k = 0; k < 500; k++) begin
      sample();
      advance();
      if (!(bus.i_req && !eg_i)) begin
        bus.i_req = $urandom_range(0, 3) != 0;
        bus.i_addr = 16'($urandom_range(0, 31));
      end
      if (!(bus.d_req && !eg_d)) begin
        bus.d_req = $urandom_range(0, 3) != 0;
        bus.d_we = $urandom_range(0, 1) == 1;
        bus.d_addr = 16'($urandom_range(0, 31));
        bus.d_wdata = $urandom;
      end
      reset = $urandom_range(0, 59) == 0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
